union_find_controller: RTL and testbench
========================================

# union_find_controller

Command-level front end for the union-find parent-array memory (`ninja_memory_system`). It accepts FIND and UNION commands from the solver and walks parent pointers through the memory's single-cycle `find_req`/`union_req` port. For UNION it writes the root link and returns the resulting root. It is the sole master of that memory port and issues at most one memory request at a time.

## Interface
Parameters:
- `ADDR_W`, 6: node index width; matches the memory address/data width.
- `MAX_HOPS`, 63: maximum pointer follows per root search before the search aborts with an error.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command; high exactly when the FSM is in IDLE.
- `cmd_op`  in  1  0 = FIND, 1 = UNION.
- `cmd_a`  in  ADDR_W  FIND node, or first UNION node.
- `cmd_b`  in  ADDR_W  second UNION node; ignored for FIND.
- `rsp_valid`  out  1  response held until it is accepted.
- `rsp_ready`  in  1  response accepted.
- `rsp_root`  out  ADDR_W  resulting root.
- `rsp_merged`  out  1  UNION performed a write.
- `rsp_error`  out  1  hop limit exceeded.
- `find_req`  out  1  memory read strobe, one cycle wide.
- `find_addr`  out  ADDR_W  read address.
- `find_data`  in  ADDR_W  read data; valid when `find_ready` is high.
- `find_ready`  in  1  read completion pulse.
- `union_req`  out  1  memory write strobe, one cycle wide.
- `union_addr`  out  ADDR_W  write address.
- `union_data`  out  ADDR_W  write data.
- `union_ready`  in  1  write completion pulse.
- `op_count`  out  16  count of responses accepted; wraps from 0xFFFF to 0.

## Operation
FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP.
- **IDLE:**
  - On `cmd_valid && cmd_ready`, latch `cmd_op`, `cmd_a` and `cmd_b`.
  - Set `cur = cmd_a`, `hops = 0`, `phase = A`.
  - Go to RD_ISSUE.
- **RD_ISSUE:** drive `find_req = 1` and `find_addr = cur`, then go to RD_WAIT.
- **RD_WAIT:** wait for `find_ready`.
  - If `find_data == cur`, the root is `cur`:
    - FIND: result is `cur`, go to RESP.
    - UNION phase A: `ra = cur`, `cur = b`, `hops = 0`, `phase = B`, go to RD_ISSUE.
    - UNION phase B: `rb = cur`. If `ra == rb`, result is `ra` with `merged = 0`, go to RESP; otherwise go to WR_ISSUE.
  - Else if `hops == MAX_HOPS`, set `error = 1` and result `cur`, go to RESP. No write is issued.
  - Else `cur = find_data`, `hops = hops + 1`, go to RD_ISSUE.
- **WR_ISSUE:** drive `union_req = 1`, `union_addr = max(ra,rb)`, `union_data = min(ra,rb)`, then go to WR_WAIT. The lower index always becomes the root.
- **WR_WAIT:** on `union_ready`, set result `min(ra,rb)` and `merged = 1`, go to RESP.
- **RESP:** `rsp_valid = 1`; `rsp_root`, `rsp_merged` and `rsp_error` are held stable.
  - On `rsp_ready`, increment `op_count` and go to IDLE.
- `find_ready` and `union_ready` are ignored in every state other than their own wait state.
- `find_req` and `union_req` are never high in the same cycle.
- The address strobes are registered, zero when idle.
- The response fields are cleared on entry to IDLE.

## Timing
- Reset values: `rsp_valid`, `rsp_root`, `rsp_merged`, `rsp_error`, `find_req`, `find_addr`, `union_req`, `union_addr`, `union_data` and `op_count` are all 0. State is IDLE, so `cmd_ready` is 1.
- Reset assertion clears all state immediately, including mid-operation. Any memory completion still in flight then arrives in IDLE and is ignored.
- The memory completes every request in the cycle after the strobe.
- Latency is counted in cycles from the acceptance cycle, which is cycle 0, to the first `rsp_valid` cycle. Depth `d` is the number of pointer follows to reach a root.
  - FIND: 2d+3.
  - UNION with equal roots: 2da+2db+5.
  - UNION with distinct roots: 2da+2db+7.
- A new command is accepted no earlier than the cycle after the response handshake.
- Back-to-back operation without stalls: one response every latency+1 cycles.

## Test plan
1. Fresh memory (identity parent array), FIND 5 -> one `find_req` with addr 5; `rsp_valid` at cycle 3 with root 5, merged 0, error 0.
2. UNION(3,7) -> reads 3 then 7; `union_req` with addr 7, data 3; response root 3, merged 1 at cycle 7. Then FIND 7 -> reads 7, 3; root 3 at cycle 5.
3. After scenario 2, UNION(7,3) -> both roots are 3; no `union_req` is issued; root 3, merged 0.
4. With `MAX_HOPS = 1`: UNION(9,10), then UNION(8,9), then FIND 10 -> reads 10 (returns 9) and 9 (returns 8); response has error 1, root 9, merged 0; no write is issued.
5. Hold `rsp_ready` low for 4 cycles on a FIND -> `rsp_valid` and the response fields stay stable, `cmd_ready` stays 0, `op_count` is unchanged. After acceptance, `op_count` increments by 1 and `cmd_ready` is 1 the next cycle.
6. Assert `reset` low during RD_WAIT of a UNION -> all outputs go to 0 asynchronously and `cmd_ready` is 1. No `union_req` appears afterwards, the late `find_ready` is ignored, and a new FIND 2 completes normally after release.

Source files
------------

// File: rtl/union_find_controller.sv
// union_find_controller
//
// Command front end for the union-find parent-array memory. Accepts FIND and
// UNION commands, walks parent pointers one read at a time through the
// memory's single-cycle find/union port, and returns the resulting root. For
// a UNION of two distinct roots it links the higher index under the lower
// index, so the lower index always becomes the root.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_op 0 = FIND, 1 = UNION
//   cmd_a, cmd_b          FIND node / first UNION node, second UNION node
//   rsp_valid/rsp_ready   response handshake; rsp_root, rsp_merged, rsp_error
//   find_req/find_addr    one-cycle read strobe and address to the memory
//   find_data/find_ready  read data and completion pulse from the memory
//   union_req/union_addr/union_data  one-cycle write strobe, address, data
//   union_ready           write completion pulse from the memory
//   op_count              responses accepted, wraps at 16 bits
//   dbg_state             current FSM state encoding, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The controller raises cmd_ready only in IDLE, and once
// rsp_valid is raised the response fields stay stable until rsp_ready.
module union_find_controller #(
    parameter int ADDR_W   = 6,
    parameter int MAX_HOPS = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_a,
    input  logic [ADDR_W-1:0] cmd_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_root,
    output logic              rsp_merged,
    output logic              rsp_error,
    output logic              find_req,
    output logic [ADDR_W-1:0] find_addr,
    input  logic [ADDR_W-1:0] find_data,
    input  logic              find_ready,
    output logic              union_req,
    output logic [ADDR_W-1:0] union_addr,
    output logic [ADDR_W-1:0] union_data,
    input  logic              union_ready,
    output logic [15:0]       op_count,
    output logic [2:0]        dbg_state
);

    localparam int HOP_W = (MAX_HOPS < 1) ? 1 : $clog2(MAX_HOPS + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        WR_WAIT  = 3'd4,
        RESP     = 3'd5
    } state_t;

    state_t            state, state_next;
    logic              op_q;      // latched command: 1 = UNION
    logic [ADDR_W-1:0] b_q;       // second UNION node, searched in phase B
    logic [ADDR_W-1:0] cur;       // node currently being read
    logic [HOP_W-1:0]  hops;      // pointer follows in the current search
    logic              phase_b;   // UNION: 0 = searching a, 1 = searching b
    logic [ADDR_W-1:0] ra;        // root of a, valid during phase B
    logic [ADDR_W-1:0] lo_q;      // surviving root of a merging UNION

    logic              at_root;
    logic              hop_limit;
    logic [ADDR_W-1:0] lo_root;
    logic [ADDR_W-1:0] hi_root;

    // A node is a root when it is its own parent. In phase B the two roots
    // are ra and cur; the lower index survives.
    always_comb begin
        at_root   = (find_data == cur);
        hop_limit = (hops == HOP_W'(MAX_HOPS));
        lo_root   = (ra < cur) ? ra : cur;
        hi_root   = (ra < cur) ? cur : ra;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (cmd_valid) state_next = RD_ISSUE;
            RD_ISSUE: state_next = RD_WAIT;
            RD_WAIT: begin
                if (find_ready) begin
                    if (at_root) begin
                        if (!op_q)          state_next = RESP;
                        else if (!phase_b)  state_next = RD_ISSUE;
                        else if (ra == cur) state_next = RESP;
                        else                state_next = WR_ISSUE;
                    end else if (hop_limit) begin
                        state_next = RESP;
                    end else begin
                        state_next = RD_ISSUE;
                    end
                end
            end
            WR_ISSUE: state_next = WR_WAIT;
            WR_WAIT:  if (union_ready) state_next = RESP;
            RESP:     if (rsp_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Output decode from the state register
    always_comb begin
        cmd_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        dbg_state = state;
    end

    // Datapath and registered memory strobes. The strobes are set on the
    // transition into their issue state, so each is high for exactly the one
    // cycle spent in RD_ISSUE / WR_ISSUE and the address buses read zero
    // otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q       <= 1'b0;
            b_q        <= '0;
            cur        <= '0;
            hops       <= '0;
            phase_b    <= 1'b0;
            ra         <= '0;
            lo_q       <= '0;
            rsp_root   <= '0;
            rsp_merged <= 1'b0;
            rsp_error  <= 1'b0;
            find_req   <= 1'b0;
            find_addr  <= '0;
            union_req  <= 1'b0;
            union_addr <= '0;
            union_data <= '0;
            op_count   <= '0;
        end else begin
            find_req   <= 1'b0;
            find_addr  <= '0;
            union_req  <= 1'b0;
            union_addr <= '0;
            union_data <= '0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op;
                        b_q       <= cmd_b;
                        cur       <= cmd_a;
                        hops      <= '0;
                        phase_b   <= 1'b0;
                        find_req  <= 1'b1;
                        find_addr <= cmd_a;
                    end
                end
                RD_WAIT: begin
                    if (find_ready) begin
                        if (at_root) begin
                            if (!op_q) begin
                                rsp_root <= cur;
                            end else if (!phase_b) begin
                                ra        <= cur;
                                cur       <= b_q;
                                hops      <= '0;
                                phase_b   <= 1'b1;
                                find_req  <= 1'b1;
                                find_addr <= b_q;
                            end else if (ra == cur) begin
                                rsp_root   <= ra;
                                rsp_merged <= 1'b0;
                            end else begin
                                lo_q       <= lo_root;
                                union_req  <= 1'b1;
                                union_addr <= hi_root;
                                union_data <= lo_root;
                            end
                        end else if (hop_limit) begin
                            // Abort the search; no write follows an error.
                            rsp_error <= 1'b1;
                            rsp_root  <= cur;
                        end else begin
                            cur       <= find_data;
                            hops      <= hops + HOP_W'(1);
                            find_req  <= 1'b1;
                            find_addr <= find_data;
                        end
                    end
                end
                WR_WAIT: begin
                    if (union_ready) begin
                        rsp_root   <= lo_q;
                        rsp_merged <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_count   <= op_count + 16'd1;
                        rsp_root   <= '0;
                        rsp_merged <= 1'b0;
                        rsp_error  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_union_find_controller.sv
// Directed testbench for union_find_controller. A small parent-array memory
// model answers every strobe in the following cycle and logs the read
// addresses and {addr,data} writes it sees; each scenario task compares the
// log, the response fields and the latency against hand-computed values.
// The design is built with MAX_HOPS = 1 so the hop-limit case is reachable
// with a depth-2 chain.
module tb_union_find_controller;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid, cmd_ready, cmd_op;
    logic [ADDR_W-1:0] cmd_a, cmd_b;
    logic              rsp_valid, rsp_ready;
    logic [ADDR_W-1:0] rsp_root;
    logic              rsp_merged, rsp_error;
    logic              find_req;
    logic [ADDR_W-1:0] find_addr, find_data;
    logic              find_ready;
    logic              union_req;
    logic [ADDR_W-1:0] union_addr, union_data;
    logic              union_ready;
    logic [15:0]       op_count;
    logic [2:0]        dbg_state;

    logic              find_ready_m;
    logic              stray_find;
    logic              mem_init;
    logic [ADDR_W-1:0] mem [64];

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_ops;

    logic [ADDR_W-1:0]   rd_log[$];
    logic [2*ADDR_W-1:0] wr_log[$];
    logic [ADDR_W-1:0]   exp_q[$];
    logic [2*ADDR_W-1:0] exp_wr_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    union_find_controller #(.ADDR_W(ADDR_W), .MAX_HOPS(1)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_root(rsp_root),
        .rsp_merged(rsp_merged), .rsp_error(rsp_error),
        .find_req(find_req), .find_addr(find_addr), .find_data(find_data),
        .find_ready(find_ready),
        .union_req(union_req), .union_addr(union_addr), .union_data(union_data),
        .union_ready(union_ready),
        .op_count(op_count), .dbg_state(dbg_state)
    );

    // ---------------- memory model ----------------
    assign find_ready = find_ready_m | stray_find;

    always @(posedge clk) begin
        find_ready_m <= find_req;
        find_data    <= mem[find_addr];
        union_ready  <= union_req;
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 6'(i);
        end else if (union_req) begin
            mem[union_addr] <= union_data;
        end
        if (find_req)  rd_log.push_back(find_addr);
        if (union_req) wr_log.push_back({union_addr, union_data});
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic op, input logic [ADDR_W-1:0] a,
                         input logic [ADDR_W-1:0] b,
                         output logic [ADDR_W-1:0] root, output logic merged,
                         output logic err, output int lat);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        root = rsp_root; merged = rsp_merged; err = rsp_error;
    endtask

    task automatic accept_rsp;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_ops++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_a = '0; cmd_b = '0;
        rsp_ready = 1'b0; stray_find = 1'b0; mem_init = 1'b1; exp_ops = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_root, rsp_merged, rsp_error, find_req, find_addr,
             union_req, union_addr, union_data, op_count} !== '0)
            begin errors++; $display("FAIL reset_outputs got %b want all zero",
                {rsp_valid, rsp_root, rsp_merged, rsp_error, find_req, find_addr,
                 union_req, union_addr, union_data, op_count}); end
        checks++;
        if (cmd_ready !== 1'b1 || dbg_state !== 3'd0)
            begin errors++; $display("FAIL reset_idle got ready=%b state=%0d want 1/0", cmd_ready, dbg_state); end
        mem_init = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
            begin errors++; $display("FAIL post_release got ready=%b valid=%b want 1/0", cmd_ready, rsp_valid); end
    endtask

    task automatic test_find;
        logic [ADDR_W-1:0] root; logic m, e; int lat;
        int rb = rd_log.size();
        int wb = wr_log.size();
        issue(1'b0, 6'd5, 6'd0, root, m, e, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL find5_latency got %0d want 3", lat); end
        checks++;
        if ({root, m, e} !== {6'd5, 1'b0, 1'b0})
            begin errors++; $display("FAIL find5_rsp got root=%0d m=%b e=%b want 5/0/0", root, m, e); end
        exp_q = '{6'd5};
        checks++;
        if (rd_log.size() - rb != exp_q.size() || wr_log.size() != wb)
            begin errors++; $display("FAIL find5_mem got reads=%0d writes=%0d want 1/0", rd_log.size() - rb, wr_log.size() - wb); end
        else foreach (exp_q[i]) begin
            checks++;
            if (rd_log[rb+i] !== exp_q[i])
                begin errors++; $display("FAIL find5_read%0d got %0d want %0d", i, rd_log[rb+i], exp_q[i]); end
        end
        accept_rsp();
        checks++;
        if (op_count !== exp_ops || cmd_ready !== 1'b1)
            begin errors++; $display("FAIL find5_count got %0d ready=%b want %0d/1", op_count, cmd_ready, exp_ops); end
    endtask

    task automatic test_union;
        logic [ADDR_W-1:0] root; logic m, e; int lat;
        int rb = rd_log.size();
        int wb = wr_log.size();
        issue(1'b1, 6'd3, 6'd7, root, m, e, lat);
        checks++;
        if (lat !== 7) begin errors++; $display("FAIL union37_latency got %0d want 7", lat); end
        checks++;
        if ({root, m, e} !== {6'd3, 1'b1, 1'b0})
            begin errors++; $display("FAIL union37_rsp got root=%0d m=%b e=%b want 3/1/0", root, m, e); end
        exp_q = '{6'd3, 6'd7};
        exp_wr_q = '{{6'd7, 6'd3}};
        checks++;
        if (rd_log.size() - rb != exp_q.size() || wr_log.size() - wb != exp_wr_q.size())
            begin errors++; $display("FAIL union37_mem got reads=%0d writes=%0d want 2/1", rd_log.size() - rb, wr_log.size() - wb); end
        else begin
            foreach (exp_q[i]) begin
                checks++;
                if (rd_log[rb+i] !== exp_q[i])
                    begin errors++; $display("FAIL union37_read%0d got %0d want %0d", i, rd_log[rb+i], exp_q[i]); end
            end
            checks++;
            if (wr_log[wb] !== exp_wr_q[0])
                begin errors++; $display("FAIL union37_write got %h want %h", wr_log[wb], exp_wr_q[0]); end
        end
        accept_rsp();
        rb = rd_log.size();
        issue(1'b0, 6'd7, 6'd0, root, m, e, lat);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL find7_latency got %0d want 5", lat); end
        checks++;
        if ({root, m, e} !== {6'd3, 1'b0, 1'b0})
            begin errors++; $display("FAIL find7_rsp got root=%0d m=%b e=%b want 3/0/0", root, m, e); end
        exp_q = '{6'd7, 6'd3};
        checks++;
        if (rd_log.size() - rb != exp_q.size())
            begin errors++; $display("FAIL find7_reads got %0d want 2", rd_log.size() - rb); end
        else foreach (exp_q[i]) begin
            checks++;
            if (rd_log[rb+i] !== exp_q[i])
                begin errors++; $display("FAIL find7_read%0d got %0d want %0d", i, rd_log[rb+i], exp_q[i]); end
        end
        accept_rsp();
    endtask

    task automatic test_union_same;
        logic [ADDR_W-1:0] root; logic m, e; int lat;
        int rb = rd_log.size();
        int wb = wr_log.size();
        issue(1'b1, 6'd7, 6'd3, root, m, e, lat);
        checks++;
        if (lat !== 7) begin errors++; $display("FAIL union73_latency got %0d want 7", lat); end
        checks++;
        if ({root, m, e} !== {6'd3, 1'b0, 1'b0})
            begin errors++; $display("FAIL union73_rsp got root=%0d m=%b e=%b want 3/0/0", root, m, e); end
        exp_q = '{6'd7, 6'd3, 6'd3};
        checks++;
        if (rd_log.size() - rb != exp_q.size() || wr_log.size() != wb)
            begin errors++; $display("FAIL union73_mem got reads=%0d writes=%0d want 3/0", rd_log.size() - rb, wr_log.size() - wb); end
        else foreach (exp_q[i]) begin
            checks++;
            if (rd_log[rb+i] !== exp_q[i])
                begin errors++; $display("FAIL union73_read%0d got %0d want %0d", i, rd_log[rb+i], exp_q[i]); end
        end
        accept_rsp();
    endtask

    task automatic test_hop_limit;
        logic [ADDR_W-1:0] root; logic m, e; int lat;
        int rb;
        int wb = wr_log.size();
        issue(1'b1, 6'd9, 6'd10, root, m, e, lat);
        checks++;
        if ({root, m, e} !== {6'd9, 1'b1, 1'b0} || lat !== 7)
            begin errors++; $display("FAIL union9_10 got root=%0d m=%b e=%b lat=%0d want 9/1/0/7", root, m, e, lat); end
        accept_rsp();
        issue(1'b1, 6'd8, 6'd9, root, m, e, lat);
        checks++;
        if ({root, m, e} !== {6'd8, 1'b1, 1'b0} || lat !== 7)
            begin errors++; $display("FAIL union8_9 got root=%0d m=%b e=%b lat=%0d want 8/1/0/7", root, m, e, lat); end
        accept_rsp();
        exp_wr_q = '{{6'd10, 6'd9}, {6'd9, 6'd8}};
        checks++;
        if (wr_log.size() - wb != exp_wr_q.size())
            begin errors++; $display("FAIL chain_writes got %0d want 2", wr_log.size() - wb); end
        else foreach (exp_wr_q[i]) begin
            checks++;
            if (wr_log[wb+i] !== exp_wr_q[i])
                begin errors++; $display("FAIL chain_write%0d got %h want %h", i, wr_log[wb+i], exp_wr_q[i]); end
        end
        rb = rd_log.size();
        wb = wr_log.size();
        issue(1'b0, 6'd10, 6'd0, root, m, e, lat);
        checks++;
        if ({root, m, e} !== {6'd9, 1'b0, 1'b1})
            begin errors++; $display("FAIL hoplimit_rsp got root=%0d m=%b e=%b want 9/0/1", root, m, e); end
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL hoplimit_latency got %0d want 5", lat); end
        exp_q = '{6'd10, 6'd9};
        checks++;
        if (rd_log.size() - rb != exp_q.size() || wr_log.size() != wb)
            begin errors++; $display("FAIL hoplimit_mem got reads=%0d writes=%0d want 2/0", rd_log.size() - rb, wr_log.size() - wb); end
        else foreach (exp_q[i]) begin
            checks++;
            if (rd_log[rb+i] !== exp_q[i])
                begin errors++; $display("FAIL hoplimit_read%0d got %0d want %0d", i, rd_log[rb+i], exp_q[i]); end
        end
        accept_rsp();
    endtask

    task automatic test_rsp_stall;
        logic [ADDR_W-1:0] root; logic m, e; int lat;
        issue(1'b0, 6'd5, 6'd0, root, m, e, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL stall_latency got %0d want 3", lat); end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({rsp_valid, cmd_ready, rsp_root, rsp_merged, rsp_error, op_count}
                !== {1'b1, 1'b0, 6'd5, 1'b0, 1'b0, exp_ops})
                begin errors++; $display("FAIL stall_hold%0d got v=%b rdy=%b root=%0d m=%b e=%b cnt=%0d want 1/0/5/0/0/%0d",
                    c, rsp_valid, cmd_ready, rsp_root, rsp_merged, rsp_error, op_count, exp_ops); end
            @(posedge clk); #1;
        end
        accept_rsp();
        checks++;
        if ({op_count, cmd_ready, rsp_valid, rsp_root} !== {exp_ops, 1'b1, 1'b0, 6'd0})
            begin errors++; $display("FAIL stall_release got cnt=%0d rdy=%b v=%b root=%0d want %0d/1/0/0",
                op_count, cmd_ready, rsp_valid, rsp_root, exp_ops); end
    endtask

    task automatic test_reset_mid;
        logic [ADDR_W-1:0] root; logic m, e; int lat;
        logic bad;
        int rb = rd_log.size();
        int wb = wr_log.size();
        cmd_op = 1'b1; cmd_a = 6'd20; cmd_b = 6'd21; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (find_req !== 1'b1 || find_addr !== 6'd20)
            begin errors++; $display("FAIL mid_issue got req=%b addr=%0d want 1/20", find_req, find_addr); end
        @(posedge clk); #1;
        checks++;
        if (dbg_state !== 3'd2 || find_ready !== 1'b1)
            begin errors++; $display("FAIL mid_wait got state=%0d fr=%b want 2/1", dbg_state, find_ready); end
        reset = 1'b0;
        exp_ops = '0;
        #1;
        checks++;
        if ({rsp_valid, rsp_root, rsp_merged, rsp_error, find_req, find_addr,
             union_req, union_addr, union_data, op_count, cmd_ready} !== {51'd0, 1'b1})
            begin errors++; $display("FAIL mid_async_reset got %b want all zero, cmd_ready 1",
                {rsp_valid, rsp_root, rsp_merged, rsp_error, find_req, find_addr,
                 union_req, union_addr, union_data, op_count, cmd_ready}); end
        @(posedge clk); #1;
        reset = 1'b1;
        stray_find = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            stray_find = 1'b0;
            if (union_req || find_req || rsp_valid || !cmd_ready) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0 || rd_log.size() - rb != 1 || wr_log.size() != wb)
            begin errors++; $display("FAIL mid_quiet got activity=%b reads=%0d writes=%0d want 0/1/0",
                bad, rd_log.size() - rb, wr_log.size() - wb); end
        issue(1'b0, 6'd2, 6'd0, root, m, e, lat);
        checks++;
        if ({root, m, e} !== {6'd2, 1'b0, 1'b0} || lat !== 3)
            begin errors++; $display("FAIL mid_find2 got root=%0d m=%b e=%b lat=%0d want 2/0/0/3", root, m, e, lat); end
        accept_rsp();
        checks++;
        if (op_count !== exp_ops)
            begin errors++; $display("FAIL mid_count got %0d want %0d", op_count, exp_ops); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_find();
        test_union();
        test_union_same();
        test_hop_limit();
        test_rsp_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
